// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared widths, FSM state type and J-format opcodes for the jump-field path
package jump_pkg;

  localparam int FIELD_W   = 26;
  localparam int WORD_W    = 32;
  localparam int OPC_W     = 6;
  localparam int ADDR_HI_W = WORD_W - FIELD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [OPC_W-1:0] OPC_J   = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_JAL = 6'b000011;

  // Opcode occupies the top bits; the field is the low 26 bits of the target.
  function automatic logic [WORD_W-1:0] pack_instr(input logic [OPC_W-1:0]   opc,
                                                   input logic [FIELD_W-1:0] field);
    return {opc, field};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that either wraps or sticks at all-ones
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per inc; in saturating mode hold once every bit is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      if (!(SAT && (&count))) begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/jump_field_packer.sv
// rtl/jump_field_packer.sv - range-checks a jump target and packs {opcode, field}
module jump_field_packer
  import jump_pkg::*;
#(
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_addr,
  input  logic [OPC_W-1:0]   in_opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic [WORD_W-1:0]  out_instr,
  output logic               out_err,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   ok_count,
  output logic [CNT_W-1:0]   err_count
);

  state_t              state;
  state_t              state_nxt;
  logic                ready_en;
  logic [WORD_W-1:0]   addr_q;
  logic [OPC_W-1:0]    opc_q;
  logic                range_ok;
  logic                capture;
  logic                ok_inc;
  logic                err_inc;
  logic                load_out;

  // A target survives zero-extension only if nothing sits above the field.
  assign range_ok = (addr_q[WORD_W-1:FIELD_W] == '0);
  assign capture  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: capture, one check cycle, then hold until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = CHECK;
      CHECK:   state_nxt = (range_ok || !STRICT) ? EMIT : IDLE;
      EMIT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the state register and captured target only.
  always_comb begin
    in_ready  = (state == IDLE) && ready_en;
    out_valid = (state == EMIT);
    err_pulse = (state == CHECK) && !range_ok;
    err_inc   = (state == CHECK) && !range_ok;
    ok_inc    = (state == CHECK) && range_ok;
    load_out  = (state == CHECK) && (range_ok || !STRICT);
  end

  // Hold off in_ready for the cycle reset is asserted so nothing is taken during it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Capture the target and opcode once; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      opc_q  <= '0;
    end else if (capture) begin
      addr_q <= in_addr;
      opc_q  <= in_opcode;
    end
  end

  // Result registers load at the end of CHECK and stay frozen through EMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_field <= '0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (load_out) begin
      out_field <= addr_q[FIELD_W-1:0];
      out_instr <= pack_instr(opc_q, addr_q[FIELD_W-1:0]);
      out_err   <= !range_ok;
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .SAT (1'b0)
  ) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_inc),
    .count (ok_count)
  );

  sat_counter #(
    .W   (CNT_W),
    .SAT (1'b1)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_jump_field_packer.sv
// tb/tb_jump_field_packer.sv - scoreboard bench for strict and non-strict packers
module tb_jump_field_packer;

  typedef struct packed {
    logic [25:0] field;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // strict instance signals
  logic        iv_s, ir_s, ov_s, ordy_s, oe_s, ep_s;
  logic [31:0] ia_s, oi_s;
  logic [5:0]  io_s;
  logic [25:0] of_s;
  logic [7:0]  okc_s, erc_s;
  // non-strict instance signals
  logic        iv_l, ir_l, ov_l, ordy_l, oe_l, ep_l;
  logic [31:0] ia_l, oi_l;
  logic [5:0]  io_l;
  logic [25:0] of_l;
  logic [7:0]  okc_l, erc_l;

  exp_t q_s[$];
  exp_t q_l[$];
  int   checks = 0;
  int   errors = 0;

  jump_field_packer #(.STRICT(1'b1), .CNT_W(8)) u_strict (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir_s), .in_addr(ia_s),
    .in_opcode(io_s), .out_valid(ov_s), .out_ready(ordy_s), .out_field(of_s),
    .out_instr(oi_s), .out_err(oe_s), .err_pulse(ep_s), .ok_count(okc_s),
    .err_count(erc_s)
  );

  jump_field_packer #(.STRICT(1'b0), .CNT_W(8)) u_loose (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_l), .in_ready(ir_l), .in_addr(ia_l),
    .in_opcode(io_l), .out_valid(ov_l), .out_ready(ordy_l), .out_field(of_l),
    .out_instr(oi_l), .out_err(oe_l), .err_pulse(ep_l), .ok_count(okc_l),
    .err_count(erc_l)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // strict-side monitor: every accepted output must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov_s === 1'b1 && ordy_s === 1'b1) begin
      if (q_s.size() == 0) begin
        chk("strict_unexpected_output", oi_s, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        chk("strict_field", {6'b0, of_s}, {6'b0, e.field});
        chk("strict_instr", oi_s, e.instr);
        chk("strict_err", {31'b0, oe_s}, {31'b0, e.err});
      end
    end
  end

  // non-strict-side monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ov_l === 1'b1 && ordy_l === 1'b1) begin
      if (q_l.size() == 0) begin
        chk("loose_unexpected_output", oi_l, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = q_l.pop_front();
        chk("loose_field", {6'b0, of_l}, {6'b0, e.field});
        chk("loose_instr", oi_l, e.instr);
        chk("loose_err", {31'b0, oe_l}, {31'b0, e.err});
      end
    end
  end

  task automatic send_s(input logic [31:0] a, input logic [5:0] o);
    int n = 0;
    while (ir_s !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    ia_s = a;
    io_s = o;
    iv_s = 1'b1;
    @(posedge clk);
    #1;
    iv_s = 1'b0;
  endtask

  task automatic push_s(input logic [25:0] f, input logic [31:0] ins, input logic e);
    exp_t x;
    x.field = f;
    x.instr = ins;
    x.err   = e;
    q_s.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    iv_s = 1'b0; ia_s = '0; io_s = '0; ordy_s = 1'b0;
    iv_l = 1'b0; ia_l = '0; io_l = '0; ordy_l = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'b0, ir_s}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset values
    chk("rst_out_valid", {31'b0, ov_s}, 32'd0);
    chk("rst_out_field", {6'b0, of_s}, 32'd0);
    chk("rst_out_instr", oi_s, 32'd0);
    chk("rst_out_err", {31'b0, oe_s}, 32'd0);
    chk("rst_err_pulse", {31'b0, ep_s}, 32'd0);
    chk("rst_ok_count", {24'b0, okc_s}, 32'd0);
    chk("rst_err_count", {24'b0, erc_s}, 32'd0);
    chk("rst_in_ready", {31'b0, ir_s}, 32'd1);

    // in-range target with latency check
    ordy_s = 1'b1;
    push_s(26'h012_3456, 32'h0812_3456, 1'b0);
    send_s(32'h0012_3456, 6'b000010);
    chk("capture_drops_ready", {31'b0, ir_s}, 32'd0);
    @(negedge clk);
    chk("check_cycle_no_valid", {31'b0, ov_s}, 32'd0);
    chk("check_cycle_no_pulse", {31'b0, ep_s}, 32'd0);
    @(negedge clk);
    chk("emit_valid_at_n2", {31'b0, ov_s}, 32'd1);
    @(negedge clk);
    chk("idle_after_transfer", {31'b0, ov_s}, 32'd0);
    chk("ok_count_one", {24'b0, okc_s}, 32'd1);

    // strict drop of an out-of-range target
    send_s(32'h0400_0001, 6'b000010);
    @(negedge clk);
    chk("drop_err_pulse", {31'b0, ep_s}, 32'd1);
    chk("drop_no_valid_n1", {31'b0, ov_s}, 32'd0);
    @(negedge clk);
    chk("drop_pulse_gone", {31'b0, ep_s}, 32'd0);
    chk("drop_no_valid_n2", {31'b0, ov_s}, 32'd0);
    chk("drop_ready_back", {31'b0, ir_s}, 32'd1);
    chk("drop_err_count", {24'b0, erc_s}, 32'd1);
    chk("drop_ok_unchanged", {24'b0, okc_s}, 32'd1);

    // non-strict instance emits truncated with error flag
    begin
      exp_t x;
      x.field = 26'h000_0010;
      x.instr = 32'h0C00_0010;
      x.err   = 1'b1;
      q_l.push_back(x);
    end
    ordy_l = 1'b1;
    ia_l = 32'hFC00_0010;
    io_l = 6'b000011;
    iv_l = 1'b1;
    @(posedge clk);
    #1;
    iv_l = 1'b0;
    @(negedge clk);
    chk("loose_err_pulse", {31'b0, ep_l}, 32'd1);
    repeat (3) @(negedge clk);
    chk("loose_err_count", {24'b0, erc_l}, 32'd1);
    chk("loose_ok_count", {24'b0, okc_l}, 32'd0);

    // backpressure: hold out_ready low, offer a second item meanwhile
    ordy_s = 1'b0;
    push_s(26'h000_1000, 32'h0800_1000, 1'b0);
    push_s(26'h3FF_FFFF, 32'h0FFF_FFFF, 1'b0);
    send_s(32'h0000_1000, 6'b000010);
    repeat (2) @(negedge clk);
    ia_s = 32'h03FF_FFFF;
    io_s = 6'b000011;
    iv_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", {31'b0, ov_s}, 32'd1);
      chk("bp_field_stable", {6'b0, of_s}, 32'h0000_1000);
      chk("bp_instr_stable", oi_s, 32'h0800_1000);
      chk("bp_in_ready_low", {31'b0, ir_s}, 32'd0);
      @(negedge clk);
    end
    chk("bp_ok_count", {24'b0, okc_s}, 32'd2);
    ordy_s = 1'b1;
    begin
      int n = 0;
      while (ir_s !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("bp_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    iv_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_ok_count_after", {24'b0, okc_s}, 32'd3);

    // reset while in EMIT: pending item must vanish
    ordy_s = 1'b0;
    send_s(32'h0000_0ABC, 6'b000010);
    repeat (2) @(negedge clk);
    chk("pre_reset_valid", {31'b0, ov_s}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_valid", {31'b0, ov_s}, 32'd0);
    chk("post_reset_ok", {24'b0, okc_s}, 32'd0);
    chk("post_reset_err", {24'b0, erc_s}, 32'd0);
    chk("post_reset_field", {6'b0, of_s}, 32'd0);
    ordy_s = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_no_output", {31'b0, ov_s}, 32'd0);
    chk("post_reset_ready", {31'b0, ir_s}, 32'd1);

    // ok_count wraps after 256 in-range targets
    for (int i = 0; i < 255; i++) begin
      logic [25:0] f;
      f = 26'(i * 4099);
      push_s(f, {6'b000010, f}, 1'b0);
      send_s({6'b0, f}, 6'b000010);
    end
    repeat (4) @(negedge clk);
    chk("ok_count_ff", {24'b0, okc_s}, 32'h0000_00FF);
    push_s(26'h2AA_AAAA, 32'h0EAA_AAAA, 1'b0);
    send_s(32'h02AA_AAAA, 6'b000011);
    repeat (4) @(negedge clk);
    chk("ok_count_wrap", {24'b0, okc_s}, 32'd0);

    // err_count saturates over 300 out-of-range targets
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (i[0] ? 32'h8000_0000 : 32'h0400_0000) | 32'(i);
      send_s(a, 6'b000010);
      if (i == 254) begin
        repeat (3) @(negedge clk);
        chk("err_count_ff", {24'b0, erc_s}, 32'h0000_00FF);
      end
    end
    repeat (4) @(negedge clk);
    chk("err_count_sat", {24'b0, erc_s}, 32'h0000_00FF);
    chk("err_phase_ok_count", {24'b0, okc_s}, 32'd0);
    chk("strict_sb_drained", 32'(q_s.size()), 32'd0);
    chk("loose_sb_drained", 32'(q_l.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
